// File: rtl/divider4by2.sv
// Restoring 4-bit by 2-bit divider: one quotient bit per cycle, MSB first.
// The result goes to one of two held channels (AB/CD). Divide-by-zero short-circuits to Q=F, R=0.
module divider4by2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       E,
  input  logic       S,
  input  logic [3:0] dividend,
  input  logic [1:0] divisor,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero,
  output logic [3:0] QAB,
  output logic [1:0] RAB,
  output logic [3:0] QCD,
  output logic [1:0] RCD
);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [3:0] dq_q, dq_d;
  logic [1:0] d_q, d_d;
  logic [2:0] r_q, r_d;
  logic [1:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       zero_pend_q, zero_pend_d;
  logic       done_q, done_d;
  logic       dbz_q, dbz_d;

  logic [3:0] quot_q [2];
  logic [1:0] rem_q  [2];
  logic [3:0] quot_d [2];
  logic [1:0] rem_d  [2];

  logic       accept;
  logic       last_iter;
  logic [2:0] t;
  logic       q_bit;
  logic [2:0] r_step;
  logic [3:0] dq_step;
  logic       wr_en;
  logic [3:0] wr_quot;
  logic [1:0] wr_rem;

  // A pending divide-by-zero result blocks acceptance for its one cycle.
  assign accept    = (state_q == IDLE) && !zero_pend_q && start && !E;
  assign last_iter = (state_q == CALC) && (cnt_q == 2'd3);

  // One restoring step.
  assign t       = {r_q[1:0], dq_q[3]};
  assign q_bit   = (t >= {1'b0, d_q});
  assign r_step  = q_bit ? (t - {1'b0, d_q}) : t;
  assign dq_step = {dq_q[2:0], q_bit};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (divisor != 2'd0)) state_d = CALC;
      CALC:    if (cnt_q == 2'd3) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (state_q == CALC);
    done        = done_q;
    div_by_zero = dbz_q;
    QAB         = quot_q[0];
    RAB         = rem_q[0];
    QCD         = quot_q[1];
    RCD         = rem_q[1];
  end

  // Datapath next values
  always_comb begin
    dq_d        = dq_q;
    d_d         = d_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    dbz_d       = dbz_q;
    zero_pend_d = 1'b0;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    wr_quot     = 4'h0;
    wr_rem      = 2'b00;

    if (accept) begin
      dq_d        = dividend;
      d_d         = divisor;
      sel_d       = S;
      r_d         = 3'd0;
      cnt_d       = 2'd0;
      dbz_d       = 1'b0;
      zero_pend_d = (divisor == 2'd0);
    end

    if (zero_pend_q) begin
      done_d  = 1'b1;
      dbz_d   = 1'b1;
      wr_en   = 1'b1;
      wr_quot = 4'hF;
      wr_rem  = 2'b00;
    end

    if (state_q == CALC) begin
      dq_d  = dq_step;
      r_d   = r_step;
      cnt_d = cnt_q + 2'd1;
      if (last_iter) begin
        done_d  = 1'b1;
        wr_en   = 1'b1;
        wr_quot = dq_step;
        wr_rem  = r_step[1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q        <= 4'h0;
      d_q         <= 2'b00;
      r_q         <= 3'd0;
      cnt_q       <= 2'd0;
      sel_q       <= 1'b0;
      zero_pend_q <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      dq_q        <= dq_d;
      d_q         <= d_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      zero_pend_q <= zero_pend_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
    end
  end

  // Channel 0 is AB, channel 1 is CD; only the captured selection is written.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      always_comb begin
        quot_d[gi] = quot_q[gi];
        rem_d[gi]  = rem_q[gi];
        if (wr_en && (sel_q == gi[0])) begin
          quot_d[gi] = wr_quot;
          rem_d[gi]  = wr_rem;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          quot_q[gi] <= 4'h0;
          rem_q[gi]  <= 2'b00;
        end else begin
          quot_q[gi] <= quot_d[gi];
          rem_q[gi]  <= rem_d[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_divider4by2.sv
// Self-checking bench for divider4by2: vector table, hand-written corner sequences,
// exhaustive round-trip and randomized requests against an arithmetic reference.
module tb_divider4by2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       E;
  logic       S;
  logic [3:0] dividend;
  logic [1:0] divisor;
  logic       busy;
  logic       done;
  logic       div_by_zero;
  logic [3:0] QAB;
  logic [1:0] RAB;
  logic [3:0] QCD;
  logic [1:0] RCD;

  int total = 0;
  int bad   = 0;

  // Expected held channel contents (0 = AB, 1 = CD)
  logic [3:0] mq [2];
  logic [1:0] mr [2];

  typedef struct {
    logic [3:0] a;
    logic [1:0] b;
    logic       s;
    logic [3:0] q;
    logic [1:0] r;
    bit         dz;
  } vec_t;

  vec_t vecs [6];

  divider4by2 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .E           (E),
    .S           (S),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .QAB         (QAB),
    .RAB         (RAB),
    .QCD         (QCD),
    .RCD         (RCD)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_chan(input string name);
    chk({name, ".QAB"}, 32'(QAB), 32'(mq[0]));
    chk({name, ".RAB"}, 32'(RAB), 32'(mr[0]));
    chk({name, ".QCD"}, 32'(QCD), 32'(mq[1]));
    chk({name, ".RCD"}, 32'(RCD), 32'(mr[1]));
  endtask

  // Issue one request and check the full cycle-by-cycle response.
  // disturb: wiggle inputs during CALC (incl. a start at edge k+2).
  // no_tail: return right after the done cycle so the caller can accept back-to-back.
  task automatic run_div(input logic [3:0] a, input logic [1:0] b, input logic s,
                         input logic [3:0] eq, input logic [1:0] er,
                         input bit disturb, input bit no_tail);
    dividend = a;
    divisor  = b;
    S        = s;
    E        = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    if (b != 2'd0) begin
      for (int i = 0; i < 4; i++) begin
        chk("busy_calc", 32'(busy), 32'd1);
        chk("done_calc", 32'(done), 32'd0);
        chk("dbz_clear", 32'(div_by_zero), 32'd0);
        chk_chan("hold_calc");
        if (disturb) begin
          E        = 1'($urandom);
          S        = 1'($urandom);
          dividend = 4'($urandom);
          divisor  = 2'($urandom);
          start    = (i == 1);
        end
        tick();
      end
      start = 1'b0;
      mq[s] = eq;
      mr[s] = er;
      chk("done_pulse", 32'(done), 32'd1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("dbz_valid", 32'(div_by_zero), 32'd0);
      chk_chan("result");
    end else begin
      chk("zero_busy", 32'(busy), 32'd0);
      chk("zero_done_early", 32'(done), 32'd0);
      chk("zero_dbz_early", 32'(div_by_zero), 32'd0);
      chk_chan("zero_hold");
      tick();
      mq[s] = eq;
      mr[s] = er;
      chk("zero_done", 32'(done), 32'd1);
      chk("zero_busy2", 32'(busy), 32'd0);
      chk("zero_dbz", 32'(div_by_zero), 32'd1);
      chk_chan("zero_result");
    end
    $display("txn %0d/%0d ch=%s -> Q=%0d R=%0d dbz=%0d", a, b, s ? "CD" : "AB",
             s ? QCD : QAB, s ? RCD : RAB, div_by_zero);
    if (!no_tail) begin
      tick();
      chk("done_fall", 32'(done), 32'd0);
      chk("busy_idle", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    logic [3:0] ra;
    logic [1:0] rb;
    logic       rs;

    rst = 1'b1; start = 1'b0; E = 1'b1; S = 1'b0; dividend = 4'h0; divisor = 2'b00;
    for (int c = 0; c < 2; c++) begin
      mq[c] = 4'h0;
      mr[c] = 2'b00;
    end
    repeat (2) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    chk_chan("rst");
    rst = 1'b0;
    tick();
    chk("idle_done", 32'(done), 32'd0);
    chk_chan("idle");

    // Vector table; dz rows run back-to-back into the next row.
    vecs[0] = '{4'd9,  2'd2, 1'b0, 4'd4,  2'd1, 1'b0};
    vecs[1] = '{4'd15, 2'd1, 1'b1, 4'd15, 2'd0, 1'b0};
    vecs[2] = '{4'd7,  2'd0, 1'b0, 4'hF,  2'd0, 1'b1};
    vecs[3] = '{4'd13, 2'd3, 1'b1, 4'd4,  2'd1, 1'b0};
    vecs[4] = '{4'd3,  2'd3, 1'b0, 4'd1,  2'd0, 1'b0};
    vecs[5] = '{4'd2,  2'd3, 1'b1, 4'd0,  2'd2, 1'b0};
    for (int v = 0; v < 6; v++)
      run_div(vecs[v].a, vecs[v].b, vecs[v].s, vecs[v].q, vecs[v].r, 1'b0, vecs[v].dz);

    // start with E=1 is ignored
    dividend = 4'd5; divisor = 2'd1; S = 1'b0; E = 1'b1; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("e_high_busy", 32'(busy), 32'd0);
      chk("e_high_done", 32'(done), 32'd0);
      chk_chan("e_high");
    end
    start = 1'b0; E = 1'b0;
    tick();

    // start and input changes during CALC are ignored
    run_div(4'd9, 2'd2, 1'b0, 4'd4, 2'd1, 1'b1, 1'b0);

    // Back-to-back: next accept at the edge where done falls
    run_div(4'd12, 2'd3, 1'b1, 4'd4, 2'd0, 1'b0, 1'b1);
    run_div(4'd5, 2'd2, 1'b0, 4'd2, 2'd1, 1'b0, 1'b0);

    // Reset in the middle of a 6/3 division
    dividend = 4'd6; divisor = 2'd3; S = 1'b0; E = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    for (int c = 0; c < 2; c++) begin
      mq[c] = 4'h0;
      mr[c] = 2'b00;
    end
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_dbz", 32'(div_by_zero), 32'd0);
    chk_chan("rst_mid");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk_chan("post_rst");
    end
    run_div(4'd6, 2'd3, 1'b0, 4'd2, 2'd0, 1'b0, 1'b0);

    // Exhaustive round trip: (A*B)/B == A rem 0 on both channels
    for (int a = 0; a < 4; a++)
      for (int b = 1; b < 4; b++)
        for (int s = 0; s < 2; s++)
          run_div(4'(a * b), 2'(b), 1'(s), 4'(a), 2'd0, 1'b0, 1'b0);

    // Randomized requests against plain integer division
    for (int n = 0; n < 40; n++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 2'($urandom_range(3, 0));
      rs = 1'($urandom_range(1, 0));
      if (rb == 2'd0)
        run_div(ra, rb, rs, 4'hF, 2'd0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      else
        run_div(ra, rb, rs, 4'(int'(ra) / int'(rb)), 2'(int'(ra) % int'(rb)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
